// File: rtl/pulse_period_monitor.sv
// rtl/pulse_period_monitor.sv - lock/violation monitor for a periodic one-cycle pulse
//
// Purpose: measures spacing between pulses on pin_i, declares lock after
// LOCK_COUNT consecutive on-time pulses and flags every early or missing
// pulse while locked.
//
// Optional feature macro: PULSE_MON_STATS_EN (builds the saturating err_count).
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous active-high reset
//   pin_i        pulse input, synchronous to clk_i
//   locked_o     registered, high while LOCKED
//   err_o        registered, one-cycle pulse per violation seen in LOCKED
//   expect_o     combinational, high when not HUNT and phase is the last slot
//   phase_o      registered, cycles since last accepted pulse minus 1
//   err_count_o  saturating error tally (0 when stats are not built)
module pulse_period_monitor #(
  parameter int PERIOD     = 3,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pin_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             expect_o,
  output logic [CNT_W-1:0] phase_o,
  output logic [7:0]       err_count_o
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [GOOD_W-1:0]   good_inc;
  logic                locked_q;
  logic                err_q, err_d;
  logic                slot_last;

  assign slot_last = (cnt_q == CNT_LAST);
  assign good_inc  = good_q + GOOD_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    err_d   = 1'b0;
    unique case (state_q)
      HUNT: begin
        cnt_d = '0;
        if (pin_i) begin
          // This pulse becomes the phase reference.
          good_d  = '0;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (slot_last) begin
          cnt_d = '0;
          if (pin_i) begin
            good_d = good_inc;
            if (good_inc == GOOD_LOCK) state_d = LOCKED;
          end else begin
            good_d  = '0;
            state_d = HUNT;
          end
        end else if (pin_i) begin
          // Early pulse silently re-references the phase.
          cnt_d  = '0;
          good_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (slot_last) begin
          cnt_d = '0;
          if (!pin_i) begin
            err_d   = 1'b1;
            good_d  = '0;
            state_d = HUNT;
          end
        end else if (pin_i) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          good_d  = '0;
          state_d = TRACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      locked_q <= (state_d == LOCKED);
      err_q    <= err_d;
    end
  end

  assign locked_o = locked_q;
  assign err_o    = err_q;
  assign phase_o  = cnt_q;
  assign expect_o = (state_q != HUNT) && slot_last;

`ifdef PULSE_MON_STATS_EN
  logic [7:0] err_count_q;

  // Counts cycles with err high; sticks at 255 until reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_count_q <= 8'd0;
    end else if (err_q && (err_count_q != 8'hff)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count_o = err_count_q;
`else
  assign err_count_o = 8'd0;
`endif

endmodule

// File: tb/tb_pulse_period_monitor.sv
// tb/tb_pulse_period_monitor.sv - directed self-checking bench for pulse_period_monitor
module tb_pulse_period_monitor;

`ifdef PULSE_MON_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       pin_i = 1'b0;
  logic       locked_o, err_o, expect_o;
  logic [1:0] phase_o;
  logic [7:0] err_count_o;

  logic       pin1 = 1'b0;
  logic       locked1, err1, expect1;
  logic [0:0] phase1;
  logic [7:0] err_count1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = -1;

  always #5 clk_i = ~clk_i;

  pulse_period_monitor #(.PERIOD(3), .LOCK_COUNT(4), .CNT_W(2)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .pin_i      (pin_i),
    .locked_o   (locked_o),
    .err_o      (err_o),
    .expect_o   (expect_o),
    .phase_o    (phase_o),
    .err_count_o(err_count_o)
  );

  pulse_period_monitor #(.PERIOD(1), .LOCK_COUNT(1), .CNT_W(1)) dut_p1 (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .pin_i      (pin1),
    .locked_o   (locked1),
    .err_o      (err1),
    .expect_o   (expect1),
    .phase_o    (phase1),
    .err_count_o(err_count1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Drive pin for the next cycle, then sample outputs at the falling edge.
  task automatic tick(input logic p);
    @(posedge clk_i);
    cyc++;
    #1 pin_i = p;
    @(negedge clk_i);
  endtask

  task automatic lock_then_miss();
    tick(1'b1);
    repeat (4) begin
      tick(1'b0);
      tick(1'b0);
      tick(1'b1);
    end
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    pin_i   = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("rst_locked", locked_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_phase", phase_o, 0);
    check_eq("rst_expect", expect_o, 0);
    check_eq("rst_err_count", err_count_o, 0);
    reset_i = 1'b0;

    // Acquire lock from pulses at 2,5,8,11,14
    for (int c = 0; c <= 14; c++) begin
      tick(c % 3 == 2);
      check_eq("acq_locked", locked_o, 0);
      check_eq("acq_err", err_o, 0);
      if (c == 5) begin
        check_eq("acq_expect", expect_o, 1);
        check_eq("acq_phase", phase_o, 2);
      end
    end
    tick(1'b0);  // 15
    check_eq("lock_at_15", locked_o, 1);
    check_eq("phase_15", phase_o, 0);
    tick(1'b0);  // 16
    check_eq("phase_16", phase_o, 1);
    check_eq("expect_16", expect_o, 0);
    tick(1'b0);  // 17: pulse suppressed
    check_eq("expect_17", expect_o, 1);
    check_eq("locked_17", locked_o, 1);
    check_eq("err_17", err_o, 0);
    tick(1'b0);  // 18
    check_eq("miss_err", err_o, 1);
    check_eq("miss_locked", locked_o, 0);
    check_eq("miss_expect", expect_o, 0);

    // Re-reference at 20, relock after 23,26,29,32; extra pulse at 33
    for (int c = 19; c <= 33; c++) begin
      tick(c == 20 || (c > 20 && (c - 20) % 3 == 0) || c == 33);
      if (c == 19) begin
        check_eq("miss_err_once", err_o, 0);
        check_eq("miss_err_count", err_count_o, STATS);
      end
      if (c == 32) check_eq("relock_32", locked_o, 0);
      if (c == 33) begin
        check_eq("relock_33", locked_o, 1);
        check_eq("relock_phase", phase_o, 0);
      end
    end

    // Early pulse at 33 is the new reference: on-time at 36,39,42,45
    for (int c = 34; c <= 47; c++) begin
      tick(c >= 36 && c <= 45 && (c - 36) % 3 == 0);
      if (c == 34) begin
        check_eq("early_err", err_o, 1);
        check_eq("early_locked", locked_o, 0);
        check_eq("early_phase", phase_o, 0);
      end
      if (c == 35) begin
        check_eq("early_err_once", err_o, 0);
        check_eq("early_err_count", err_count_o, 2 * STATS);
      end
      if (c == 36) check_eq("early_expect", expect_o, 1);
      if (c == 45) check_eq("relock2_45", locked_o, 0);
      if (c == 46) check_eq("relock2_46", locked_o, 1);
      if (c == 47) check_eq("pre_rst_phase", phase_o, 1);
    end

    // Asynchronous reset between edges
    #2 reset_i = 1'b1;
    #1;
    check_eq("arst_locked", locked_o, 0);
    check_eq("arst_err", err_o, 0);
    check_eq("arst_phase", phase_o, 0);
    check_eq("arst_err_count", err_count_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // PERIOD=1, LOCK_COUNT=1 instance: held-high pin is all on-time
    pin1 = 1'b1;
    tick(1'b0);
    check_eq("p1_track_locked", locked1, 0);
    check_eq("p1_track_expect", expect1, 1);
    tick(1'b0);
    check_eq("p1_locked", locked1, 1);
    tick(1'b0);
    check_eq("p1_hold_locked", locked1, 1);
    check_eq("p1_hold_err", err1, 0);
    pin1 = 1'b0;
    tick(1'b0);
    check_eq("p1_miss_err", err1, 1);
    check_eq("p1_miss_locked", locked1, 0);
    tick(1'b0);
    check_eq("p1_err_once", err1, 0);

    // Pin held high at PERIOD=3: loops in TRACK, never locks, never errs
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      check_eq("held_locked", locked_o, 0);
      check_eq("held_err", err_o, 0);
      if (i > 0) check_eq("held_phase", phase_o, 0);
    end

    // Error tally
    do_reset();
    repeat (3) lock_then_miss();
    tick(1'b0);
    check_eq("tally_err", err_o, 1);
    tick(1'b0);
    check_eq("tally_3", err_count_o, 3 * STATS);
    if (STATS == 1) begin
      repeat (297) lock_then_miss();
      tick(1'b0);
      tick(1'b0);
      check_eq("tally_sat", err_count_o, 255);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
